// File: rtl/dmem_pkg.sv
// Shared sizes, request/response types and helpers for the data-memory arbiter.
package dmem_pkg;

  localparam int DMEM_DEPTH  = 64;
  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 32;

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic                   valid;
    logic                   err;
    logic [DMEM_DATA_W-1:0] rdata;
  } dmem_rsp_t;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } dmem_port_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with the last-winner register.
// Grant is combinational; it is forced to zero while reset is asserted.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  dmem_port_e last_q;
  dmem_port_e last_d;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // On a tie, the port that did not win last time goes first.
        2'b11:   grant = (last_q == PORT1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant[0]) begin
      last_d = PORT0;
    end else if (grant[1]) begin
      last_d = PORT1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported word memory between two requesters, one access per cycle.
// Optional DMEM_ARB_PERF_CNT_EN adds saturating grant/conflict counters.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int MEM_DEPTH = DMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,

  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,

  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
`ifdef DMEM_ARB_PERF_CNT_EN
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_conflict,
`endif
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  dmem_req_t  req0;
  dmem_req_t  req1;
  dmem_req_t  acc;
  logic [1:0] grant;
  logic       any_grant;
  logic       in_range;
  dmem_rsp_t  rsp_new;
  dmem_rsp_t  rsp0_d, rsp0_q;
  dmem_rsp_t  rsp1_d, rsp1_q;

  assign req0 = '{valid: req0_valid, we: req0_we, addr: req0_addr, wdata: req0_wdata};
  assign req1 = '{valid: req1_valid, we: req1_we, addr: req1_addr, wdata: req1_wdata};

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .valid ({req1.valid, req0.valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    acc         = grant[1] ? req1 : req0;
    any_grant   = (|grant) & acc.valid;
    in_range    = (acc.addr < DEPTH_A);
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    // Out-of-range transfers are accepted but never reach the memory.
    if (any_grant && in_range) begin
      mem_addr = acc.addr;
      if (acc.we) begin
        mem_wr      = 1'b1;
        mem_wr_data = acc.wdata;
      end else begin
        mem_rd = 1'b1;
      end
    end
  end

  always_comb begin
    rsp_new.valid = any_grant;
    rsp_new.err   = any_grant & ~in_range;
    rsp_new.rdata = mem_rd ? mem_data_out : '0;
    rsp0_d        = grant[0] ? rsp_new : '0;
    rsp1_d        = grant[1] ? rsp_new : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_q <= '0;
      rsp1_q <= '0;
    end else begin
      rsp0_q <= rsp0_d;
      rsp1_q <= rsp1_d;
    end
  end

  assign rsp0_valid = rsp0_q.valid;
  assign rsp0_err   = rsp0_q.err;
  assign rsp0_rdata = rsp0_q.rdata;
  assign rsp1_valid = rsp1_q.valid;
  assign rsp1_err   = rsp1_q.err;
  assign rsp1_rdata = rsp1_q.rdata;

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] pg0_q, pg0_d;
  logic [31:0] pg1_q, pg1_d;
  logic [31:0] pcf_q, pcf_d;

  always_comb begin
    pg0_d = grant[0] ? sat_inc32(pg0_q) : pg0_q;
    pg1_d = grant[1] ? sat_inc32(pg1_q) : pg1_q;
    pcf_d = (req0_valid && req1_valid) ? sat_inc32(pcf_q) : pcf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pg0_q <= '0;
      pg1_q <= '0;
      pcf_q <= '0;
    end else begin
      pg0_q <= pg0_d;
      pg1_q <= pg1_d;
      pcf_q <= pcf_d;
    end
  end

  assign perf_grant0   = pg0_q;
  assign perf_grant1   = pg1_q;
  assign perf_conflict = pcf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a random run against a reference model.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_rdata;
  logic          req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_rdata;
  logic          mem_wr, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_data_out;
`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0]   perf_grant0, perf_grant1, perf_conflict;
`endif

  dmem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_we      (req0_we),
    .req0_addr    (req0_addr),
    .req0_wdata   (req0_wdata),
    .req0_ready   (req0_ready),
    .rsp0_valid   (rsp0_valid),
    .rsp0_rdata   (rsp0_rdata),
    .rsp0_err     (rsp0_err),
    .req1_valid   (req1_valid),
    .req1_we      (req1_we),
    .req1_addr    (req1_addr),
    .req1_wdata   (req1_wdata),
    .req1_ready   (req1_ready),
    .rsp1_valid   (rsp1_valid),
    .rsp1_rdata   (rsp1_rdata),
    .rsp1_err     (rsp1_err),
    .mem_wr       (mem_wr),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
`ifdef DMEM_ARB_PERF_CNT_EN
    .perf_grant0  (perf_grant0),
    .perf_grant1  (perf_grant1),
    .perf_conflict(perf_conflict),
`endif
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Physical memory the arbiter drives: combinational read, write on rising edge.
  logic [DW-1:0] mem_arr [0:DEPTH-1];
  assign mem_data_out = (mem_addr < DEPTH) ? mem_arr[mem_addr[5:0]] : '0;
  always @(posedge clk) if (mem_wr && (mem_addr < DEPTH)) mem_arr[mem_addr[5:0]] <= mem_wr_data;

  // Reference model state.
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int            last_win;
  logic [31:0]   m_g0, m_g1, m_conf;

  // Per-cycle results: comb = {ready0,ready1,mem_wr,mem_rd,mem_addr,mem_wr_data}
  //                    rsp  = {v0,e0,rdata0,v1,e1,rdata1}
  int            g;
  logic [67:0]   obs_comb, exp_comb, cmp_mask, obs_rsp, exp_rsp;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void model_reset();
    last_win = 1;
    m_g0     = 0;
    m_g1     = 0;
    m_conf   = 0;
  endfunction

  task automatic run_cycle(input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [33:0]   r;
    @(negedge clk);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    #1;
    obs_comb = {req0_ready, req1_ready, mem_wr, mem_rd, mem_addr, mem_wr_data};
    g = -1;
    if (v0 && v1) g = (last_win == 0) ? 1 : 0;
    else if (v0)  g = 0;
    else if (v1)  g = 1;
    if (v0 && v1 && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 1;
    exp_comb = '0;
    cmp_mask = '1;
    exp_rsp  = '0;
    if (g >= 0) begin
      we = (g == 1) ? we1 : we0;
      a  = (g == 1) ? a1  : a0;
      d  = (g == 1) ? d1  : d0;
      exp_comb[67:66] = (g == 0) ? 2'b10 : 2'b01;
      if (a < DEPTH) begin
        exp_comb[63:32] = a;
        if (we) begin
          exp_comb[65]    = 1'b1;
          exp_comb[31:0]  = d;
          ref_mem[a[5:0]] = d;
          r = {1'b1, 1'b0, 32'h0};
        end else begin
          exp_comb[64]   = 1'b1;
          cmp_mask[31:0] = '0;
          r = {1'b1, 1'b0, ref_mem[a[5:0]]};
        end
      end else begin
        cmp_mask[63:0] = '0;
        r = {1'b1, 1'b1, 32'h0};
      end
      if (g == 0) begin
        exp_rsp[67:34] = r;
        if (m_g0 != 32'hFFFF_FFFF) m_g0 = m_g0 + 1;
      end else begin
        exp_rsp[33:0] = r;
        if (m_g1 != 32'hFFFF_FFFF) m_g1 = m_g1 + 1;
      end
      last_win = g;
    end
    @(posedge clk);
    #1;
    obs_rsp = {rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({req0_ready, req1_ready, mem_wr, mem_rd, mem_addr, mem_wr_data} !== 68'h0)
      $display("FAIL reset_comb got %h want 0", {req0_ready, req1_ready, mem_wr, mem_rd, mem_addr, mem_wr_data});
    else n_pass++;
    n_checks++;
    if ({rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata} !== 68'h0)
      $display("FAIL reset_rsp got %h want 0", {rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata});
    else n_pass++;
    req0_valid = 1; req1_valid = 1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready, mem_rd} !== 3'b000)
      $display("FAIL reset_forces_ready got %b want 000", {req0_ready, req1_ready, mem_rd});
    else n_pass++;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_comb !== 68'h0 || obs_rsp !== 68'h0)
      $display("FAIL idle got comb %h rsp %h want 0 0", obs_comb, obs_rsp);
    else n_pass++;
    run_cycle(1, 0, 1, 0, 1, 0, 2, 0);
    n_checks++;
    if (obs_comb[67:66] !== 2'b10)
      $display("FAIL first_tie_grant got %b want 10", obs_comb[67:66]);
    else n_pass++;
  endtask

  task automatic test_write_read();
    run_cycle(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    n_checks++;
    if ({obs_comb[65:64], obs_comb[63:32], obs_comb[31:0]} !== {2'b10, 32'd5, 32'hDEAD_BEEF})
      $display("FAIL write_mem got wr/rd %b addr %h data %h want 10 5 deadbeef",
               obs_comb[65:64], obs_comb[63:32], obs_comb[31:0]);
    else n_pass++;
    n_checks++;
    if (obs_rsp[67:34] !== {1'b1, 1'b0, 32'h0})
      $display("FAIL write_rsp got %h want %h", obs_rsp[67:34], {1'b1, 1'b0, 32'h0});
    else n_pass++;
    run_cycle(1, 0, 5, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_rsp !== {1'b1, 1'b0, 32'hDEAD_BEEF, 34'h0})
      $display("FAIL read_after_write got %h want %h", obs_rsp, {1'b1, 1'b0, 32'hDEAD_BEEF, 34'h0});
    else n_pass++;
  endtask

  task automatic test_alternate();
    logic [67:0] want;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_cycle(1, 0, 1, 0, 1, 0, 2, 0);
      n_checks++;
      if (obs_comb[67:66] !== ((i % 2 == 0) ? 2'b10 : 2'b01))
        $display("FAIL alt_grant[%0d] got %b", i, obs_comb[67:66]);
      else n_pass++;
      want = (i % 2 == 0) ? {1'b1, 1'b0, ref_mem[1], 34'h0} : {34'h0, 1'b1, 1'b0, ref_mem[2]};
      n_checks++;
      if (obs_rsp !== want)
        $display("FAIL alt_rsp[%0d] got %h want %h", i, obs_rsp, want);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    run_cycle(0, 0, 0, 0, 1, 0, 64, 0);
    n_checks++;
    if ({obs_comb[66], obs_comb[64]} !== 2'b10 || obs_rsp[33:0] !== {1'b1, 1'b1, 32'h0})
      $display("FAIL oor_read got ready/rd %b rsp %h", {obs_comb[66], obs_comb[64]}, obs_rsp[33:0]);
    else n_pass++;
    run_cycle(0, 0, 0, 0, 1, 1, 100, 32'h1234_5678);
    n_checks++;
    if ({obs_comb[66], obs_comb[65]} !== 2'b10 || obs_rsp[33:0] !== {1'b1, 1'b1, 32'h0})
      $display("FAIL oor_write got ready/wr %b rsp %h", {obs_comb[66], obs_comb[65]}, obs_rsp[33:0]);
    else n_pass++;
    run_cycle(0, 0, 0, 0, 1, 0, 63, 0);
    n_checks++;
    if (obs_comb[64] !== 1'b1 || obs_rsp[33:0] !== {1'b1, 1'b0, ref_mem[63]})
      $display("FAIL last_word got rd %b rsp %h want 1 %h", obs_comb[64], obs_rsp[33:0], {1'b1, 1'b0, ref_mem[63]});
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    run_cycle(1, 0, 3, 0, 0, 0, 0, 0);
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({rsp0_valid, rsp0_rdata} !== 33'h0)
      $display("FAIL inflight_drop got %h want 0", {rsp0_valid, rsp0_rdata});
    else n_pass++;
    req0_valid = 0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({rsp0_valid, mem_wr} !== 2'b00 || mem_arr[3] !== ref_mem[3])
      $display("FAIL inflight_hold got v/wr %b mem %h want 00 %h", {rsp0_valid, mem_wr}, mem_arr[3], ref_mem[3]);
    else n_pass++;
    reset = 1'b0;
    run_cycle(0, 0, 0, 0, 1, 0, 7, 0);
    n_checks++;
    if (obs_comb[67:66] !== 2'b01 || obs_rsp !== {34'h0, 1'b1, 1'b0, ref_mem[7]})
      $display("FAIL post_reset_p1 got grant %b rsp %h", obs_comb[67:66], obs_rsp);
    else n_pass++;
  endtask

  task automatic test_random();
    logic          p0v, p0we, p1v, p1we;
    logic [AW-1:0] p0a, p1a;
    logic [DW-1:0] p0d, p1d;
    int            bad_c, bad_r;
    p0v = 0; p1v = 0; p0we = 0; p1we = 0; p0a = 0; p1a = 0; p0d = 0; p1d = 0;
    bad_c = 0; bad_r = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!p0v && $urandom_range(0, 99) < 60) begin
        p0v = 1; p0we = 1'($urandom_range(0, 1)); p0d = $urandom;
        p0a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 69);
      end
      if (!p1v && $urandom_range(0, 99) < 60) begin
        p1v = 1; p1we = 1'($urandom_range(0, 1)); p1d = $urandom;
        p1a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 69);
      end
      run_cycle(p0v, p0we, p0a, p0d, p1v, p1we, p1a, p1d);
      n_checks++;
      if (((obs_comb ^ exp_comb) & cmp_mask) !== 68'h0) begin
        if (bad_c < 5) $display("FAIL rand_comb[%0d] got %h want %h", i, obs_comb & cmp_mask, exp_comb & cmp_mask);
        bad_c++;
      end else n_pass++;
      n_checks++;
      if (obs_rsp !== exp_rsp) begin
        if (bad_r < 5) $display("FAIL rand_rsp[%0d] got %h want %h", i, obs_rsp, exp_rsp);
        bad_r++;
      end else n_pass++;
      if (g == 0) p0v = 0;
      if (g == 1) p1v = 0;
    end
`ifdef DMEM_ARB_PERF_CNT_EN
    n_checks++;
    if ({perf_grant0, perf_grant1, perf_conflict} !== {m_g0, m_g1, m_conf})
      $display("FAIL rand_perf got %h want %h", {perf_grant0, perf_grant1, perf_conflict}, {m_g0, m_g1, m_conf});
    else n_pass++;
`endif
  endtask

`ifdef DMEM_ARB_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    repeat (3) run_cycle(1, 0, 1, 0, 1, 0, 2, 0);
    repeat (2) run_cycle(0, 0, 0, 0, 1, 0, 4, 0);
    n_checks++;
    if ({perf_conflict, perf_grant0, perf_grant1} !== {32'd3, 32'd2, 32'd3})
      $display("FAIL perf got conf %0d g0 %0d g1 %0d want 3 2 3", perf_conflict, perf_grant0, perf_grant1);
    else n_pass++;
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] <= 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      ref_mem[i]  = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    test_reset();
    test_write_read();
    test_alternate();
    test_out_of_range();
    test_reset_inflight();
    test_random();
`ifdef DMEM_ARB_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-ported, word-addressed data memory between the core load/store unit (port 0) and the debug/DMA loader (port 1).
- Round-robin grant, at most one access per cycle.
- Drives the memory's mem_wr, mem_rd, addr and wr_data inputs.
- Returns registered read data or write acknowledge to the winning requester one cycle after acceptance.

Parameters:
- ADDR_W, 32, requester and memory address width (word index, not byte address).
- DATA_W, 32, data width.
- MEM_DEPTH, 64, number of implemented memory words; addresses >= MEM_DEPTH are out of range.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request.
- req0_we  in  1  port 0: 1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 word address.
- req0_wdata  in  DATA_W  port 0 write data.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 response pulse.
- rsp0_rdata  out  DATA_W  port 0 read data.
- rsp0_err  out  1  port 0 out-of-range flag.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err: same as port 0, for port 1.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_data_out  in  DATA_W  memory combinational read data.

Behaviour:
- Reset (asynchronous, active-high):
  - rr_last=1, so port 0 wins the first tie.
  - All rsp*_valid, rsp*_err and rsp*_rdata = 0.
  - Reset forces all ready outputs and mem_wr/mem_rd/mem_addr/mem_wr_data to 0 while asserted.
  - In-flight responses are dropped, never replayed.
- Grant (combinational from valids and rr_last):
  - Only one port valid: that port wins.
  - Both valid: the port != rr_last wins.
  - None valid: no grant, and all mem outputs are 0.
- reqN_ready = grantN. A transfer occurs when valid&ready.
- Requesters hold valid, we, addr and wdata stable until ready; valid may not be withdrawn before acceptance.
- rr_last updates to the granted port on each accepted transfer and holds otherwise.
- Accepted cycle, address in range:
  - Read: mem_rd=1, mem_addr=addr.
  - Write: mem_wr=1, mem_addr=addr, mem_wr_data=wdata.
  - Memory commits the write on the same rising edge.
- Out-of-range address (addr >= MEM_DEPTH):
  - Transfer is still accepted, but mem_wr and mem_rd stay 0.
  - Response carries err=1, rdata=0.
- Response (cycle after acceptance):
  - rspN_valid=1 for exactly one cycle.
  - Read: rspN_rdata = mem_data_out sampled at the accept edge.
  - Write: rdata=0, err=0 (or err=1 if out of range).
  - There is no response back-pressure; requesters must sink it.
- Latency:
  - Accept to rsp_valid = 1 cycle.
  - Throughput is 1 transfer per cycle across both ports combined.
- A read following a write to the same address in the next cycle (either port) returns the new data.
- Response registers for the non-granted port clear to valid=0 each cycle.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- Defined: adds outputs perf_grant0, perf_grant1 (32 bits each, accepted transfers per port) and perf_conflict (32 bits, cycles with both valid).
  - Counters saturate at all-ones.
  - Counters clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg:
  - DMEM_DEPTH=64, DMEM_ADDR_W, DMEM_DATA_W.
  - typedef dmem_req_t {valid, we, addr, wdata}.
  - typedef dmem_rsp_t {valid, err, rdata}.
- One natural sub-module: rr_arbiter2, the 2-way round-robin grant plus rr_last register.
- Response registers and the range check stay in dmem_arbiter.

Test Plan:
- Reset then idle -> all ready/mem_*/rsp_* = 0; first simultaneous request (both valid) -> port 0 granted.
- Port 0 write addr=5 wdata=0xDEADBEEF, next cycle port 0 read addr=5 -> mem_wr pulse at addr 5; read response rsp0_rdata=0xDEADBEEF one cycle after accept, err=0.
- Both ports continuously valid reading addr 1 and 2 for 6 cycles -> grants alternate 0,1,0,1,0,1; each rsp_valid one cycle after its accept.
- Port 1 read addr=64 -> ready=1, mem_rd=0, rsp1_err=1, rsp1_rdata=0; port 1 write addr=100 -> mem_wr never asserted.
- Assert reset in the cycle after a port 0 read accept -> rsp0_valid stays 0, rr_last=1, memory untouched; after release, port 1 alone valid -> granted immediately.
- With DMEM_ARB_PERF_CNT_EN: 3 conflict cycles plus 2 single port-1 accesses -> perf_conflict=3, perf_grant0=2, perf_grant1=3 (conflict grants alternate 0,1,0).
